// File: rtl/match_logger_pkg.sv
// Shared definitions for the match event logger: FSM state encoding,
// counter/timestamp width and the saturation limit for match_count.
package match_logger_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

   // Saturating increment used for the match counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/match_fifo.sv
// Small capture FIFO. Head data is presented combinationally from storage;
// a push while full is accepted only when a pop happens in the same cycle.
// Pointers wrap naturally because DEPTH is a power of two.
module match_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] dout
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (count_r == DEPTH_C);
   assign empty     = (count_r == {CW{1'b0}});
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);
   // Zero while empty so the head output reads 0 after reset.
   assign dout      = empty ? {W{1'b0}} : mem_r[rd_ptr_r];

   // Storage write; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/match_event_logger.sv
// Match event logger: opens a capture window on arm, logs up to CAP_LEN
// pattern-detect matches (product values) into a FIFO, counts matches and
// flags dropped captures. Optional build macro MATCH_LOGGER_TIMESTAMP_EN adds
// a free-running 16-bit cycle counter stored with each entry (port out_ts).
module match_event_logger
   import match_logger_pkg::*;
#(
   parameter int DW      = 8,
   parameter int DEPTH   = 4,
   parameter int CAP_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic [2*DW-1:0]   product,
   input  logic              match,
   output logic              out_valid,
   output logic [2*DW-1:0]   out_data,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  match_count,
   output logic              overflow,
   output logic              busy
`ifdef MATCH_LOGGER_TIMESTAMP_EN
   ,
   output logic [CNT_W-1:0]  out_ts
`endif
);
   localparam int PW = 2 * DW;
`ifdef MATCH_LOGGER_TIMESTAMP_EN
   localparam int FW = PW + CNT_W;
`else
   localparam int FW = PW;
`endif
   localparam logic [7:0] CAP_LEN_C = 8'(CAP_LEN);

   state_t           state_r;
   logic [7:0]       cap_cnt_r;
   logic [CNT_W-1:0] match_count_r;
   logic             overflow_r;
   logic             window_s;
   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             empty_s;
   logic [7:0]       cap_next_s;
   logic [FW-1:0]    fifo_din_s;
   logic [FW-1:0]    fifo_dout_s;

   assign window_s   = (state_r == ARMED) || (state_r == CAPTURE);
   assign push_s     = match && window_s;
   assign pop_s      = out_ready && !empty_s;
   assign cap_next_s = cap_cnt_r + 8'd1;

`ifdef MATCH_LOGGER_TIMESTAMP_EN
   logic [CNT_W-1:0] ts_r;

   // Free-running cycle counter sampled into each pushed entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_r <= {CNT_W{1'b0}};
      end else begin
         ts_r <= ts_r + 16'd1;
      end
   end

   assign fifo_din_s = {ts_r, product};
   assign out_ts     = fifo_dout_s[FW-1:PW];
`else
   assign fifo_din_s = product;
`endif

   assign out_data    = fifo_dout_s[PW-1:0];
   assign out_valid   = !empty_s;
   assign match_count = match_count_r;
   assign overflow    = overflow_r;
   assign busy        = (state_r != IDLE);

   match_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (fifo_din_s),
      .full  (full_s),
      .empty (empty_s),
      .dout  (fifo_dout_s)
   );

   // Capture-window FSM with match counter, window length and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         cap_cnt_r     <= 8'd0;
         match_count_r <= {CNT_W{1'b0}};
         overflow_r    <= 1'b0;
      end else begin
         if (push_s) begin
            match_count_r <= sat_inc(match_count_r);
         end
         // A dropped push still counts toward the window length below.
         if (push_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (arm) begin
                  state_r   <= ARMED;
                  cap_cnt_r <= 8'd0;
               end
            end
            ARMED, CAPTURE: begin
               if (match) begin
                  cap_cnt_r <= cap_next_s;
                  state_r   <= (cap_next_s == CAP_LEN_C) ? DONE : CAPTURE;
               end
            end
            DONE: begin
               if (empty_s) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_match_event_logger.sv
// Self-checking bench for match_event_logger (DW=8, DEPTH=4, CAP_LEN=8).
// Expected products are queued when a match is driven that must be stored,
// and compared whenever the DUT hands an entry over (out_valid && out_ready).
module tb_match_event_logger;
   import match_logger_pkg::*;

   localparam int PW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            arm;
   logic            match;
   logic            out_ready;
   logic            out_valid;
   logic            overflow;
   logic            busy;
   logic [PW-1:0]   product;
   logic [PW-1:0]   out_data;
   logic [15:0]     match_count;
`ifdef MATCH_LOGGER_TIMESTAMP_EN
   logic [15:0]     out_ts;
`endif

   int              errors = 0;
   int              checks = 0;
   logic [PW-1:0]   exp_q[$];

   always #5 clk = ~clk;

   match_event_logger dut (
      .clk         (clk),
      .rst         (rst),
      .arm         (arm),
      .product     (product),
      .match       (match),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .match_count (match_count),
      .overflow    (overflow),
      .busy        (busy)
`ifdef MATCH_LOGGER_TIMESTAMP_EN
      ,
      .out_ts      (out_ts)
`endif
   );

   // Advance one cycle; if an entry is handed over this cycle, score it.
   task automatic tick();
      logic [PW-1:0] exp_v;
      if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: out_data=%h, required no entry", out_data);
         end else begin
            exp_v = exp_q.pop_front();
            if (out_data !== exp_v) begin
               errors++;
               $display("FAIL sb_data: out_data=%h, required %h", out_data, exp_v);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; arm = 1'b0; match = 1'b0; out_ready = 1'b0; product = 16'h0000;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; arm = 1'b0; match = 1'b0; out_ready = 1'b0; product = 16'h0000;
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, match_count, overflow, busy} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs: v=%b d=%h cnt=%h ovf=%b busy=%b, required all 0",
                  out_valid, out_data, match_count, overflow, busy);
      end
      checks++;
      if (dut.state_r !== 2'd0 || dut.cap_cnt_r !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d cap=%0d, required 0/0", dut.state_r, dut.cap_cnt_r);
      end
      rst = 1'b0;
      // Match without arm must be ignored.
      product = 16'h00AA; match = 1'b1; out_ready = 1'b1;
      tick();
      tick();
      match = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || match_count !== 16'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_push: v=%b cnt=%0d busy=%b, required 0/0/0", out_valid, match_count, busy);
      end
   endtask

   task automatic test_first_match();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      checks++;
      if (busy !== 1'b1 || dut.state_r !== 2'd1) begin
         errors++;
         $display("FAIL armed: busy=%b state=%0d, required 1/1", busy, dut.state_r);
      end
      out_ready = 1'b1; product = 16'd18; match = 1'b1;
      exp_q.push_back(16'd18);
      tick();
      match = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd18 || match_count !== 16'd1 || dut.state_r !== 2'd2) begin
         errors++;
         $display("FAIL first_match: v=%b d=%0d cnt=%0d state=%0d, required 1/18/1/2",
                  out_valid, out_data, match_count, dut.state_r);
      end
   endtask

   task automatic test_capture_window();
      for (int i = 1; i <= 7; i++) begin
         product = 16'hA000 + 16'(i); match = 1'b1;
         exp_q.push_back(product);
         tick();
      end
      match = 1'b0;
      checks++;
      if (dut.state_r !== 2'd3 || match_count !== 16'd8 || busy !== 1'b1) begin
         errors++;
         $display("FAIL window_done: state=%0d cnt=%0d busy=%b, required 3/8/1", dut.state_r, match_count, busy);
      end
      // Matches during DONE and the following IDLE must be ignored.
      product = 16'hDEAD; match = 1'b1;
      for (int n = 0; n < 10 && busy; n++) begin
         tick();
      end
      tick();
      match = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || exp_q.size() != 0 || match_count !== 16'd8) begin
         errors++;
         $display("FAIL window_idle: busy=%b v=%b pending=%0d cnt=%0d, required 0/0/0/8",
                  busy, out_valid, exp_q.size(), match_count);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         product = 16'hB000 + 16'(i); match = 1'b1;
         exp_q.push_back(product);
         tick();
      end
      match = 1'b0;
      checks++;
      if (dut.u_fifo.count_r !== 3'd4 || overflow !== 1'b0 || out_data !== 16'hB001) begin
         errors++;
         $display("FAIL fill: occ=%0d ovf=%b d=%h, required 4/0/b001", dut.u_fifo.count_r, overflow, out_data);
      end
      product = 16'hB005; match = 1'b1; out_ready = 1'b1;
      exp_q.push_back(product);
      tick();
      match = 1'b0; out_ready = 1'b0;
      checks++;
      if (dut.u_fifo.count_r !== 3'd4 || overflow !== 1'b0 || out_data !== 16'hB002 || match_count !== 16'd5) begin
         errors++;
         $display("FAIL full_pop: occ=%0d ovf=%b d=%h cnt=%0d, required 4/0/b002/5",
                  dut.u_fifo.count_r, overflow, out_data, match_count);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         product = 16'hC000 + 16'(i); match = 1'b1;
         if (i <= 4) exp_q.push_back(product);
         tick();
      end
      match = 1'b0;
      checks++;
      if (overflow !== 1'b1 || match_count !== 16'd6 || out_data !== 16'hC001 ||
          dut.u_fifo.count_r !== 3'd4 || dut.state_r !== 2'd2) begin
         errors++;
         $display("FAIL overflow: ovf=%b cnt=%0d d=%h occ=%0d state=%0d, required 1/6/c001/4/2",
                  overflow, match_count, out_data, dut.u_fifo.count_r, dut.state_r);
      end
      // Dropped matches counted toward the window: two more close it.
      out_ready = 1'b1;
      for (int i = 7; i <= 8; i++) begin
         product = 16'hC000 + 16'(i); match = 1'b1;
         exp_q.push_back(product);
         tick();
      end
      match = 1'b0;
      checks++;
      if (dut.state_r !== 2'd3) begin
         errors++;
         $display("FAIL overflow_done: state=%0d, required 3", dut.state_r);
      end
      for (int n = 0; n < 20 && busy; n++) begin
         tick();
      end
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || exp_q.size() != 0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_drain: busy=%b pending=%0d ovf=%b, required 0/0/1", busy, exp_q.size(), overflow);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         product = 16'hD000 + 16'(i); match = 1'b1;
         exp_q.push_back(product);
         tick();
      end
      match = 1'b0;
      checks++;
      if (dut.u_fifo.count_r !== 3'd3 || out_valid !== 1'b1 || dut.state_r !== 2'd2) begin
         errors++;
         $display("FAIL pre_reset: occ=%0d v=%b state=%0d, required 3/1/2", dut.u_fifo.count_r, out_valid, dut.state_r);
      end
      rst = 1'b1;
      exp_q.delete();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: v=%b, required 0", out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (match_count !== 16'd0 || dut.state_r !== 2'd0 || out_valid !== 1'b0 ||
          overflow !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset: cnt=%0d state=%0d v=%b ovf=%b busy=%b d=%h, required 0/0/0/0/0/0",
                  match_count, dut.state_r, out_valid, overflow, busy, out_data);
      end
      product = 16'h0BAD; match = 1'b1; out_ready = 1'b1;
      tick();
      tick();
      match = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || match_count !== 16'd0) begin
         errors++;
         $display("FAIL post_reset_match: v=%b cnt=%0d, required 0/0", out_valid, match_count);
      end
   endtask

`ifdef MATCH_LOGGER_TIMESTAMP_EN
   task automatic test_timestamp();
      do_reset();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      repeat (9) tick();
      product = 16'hE00A; match = 1'b1;
      exp_q.push_back(product);
      tick();
      match = 1'b0;
      tick();
      tick();
      product = 16'hE00D; match = 1'b1;
      exp_q.push_back(product);
      tick();
      match = 1'b0;
      checks++;
      if (out_ts !== 16'd10) begin
         errors++;
         $display("FAIL ts_first: out_ts=%0d, required 10", out_ts);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_ts !== 16'd13) begin
         errors++;
         $display("FAIL ts_second: out_ts=%0d, required 13", out_ts);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_match();
      test_capture_window();
      test_full_pop();
      test_overflow();
      test_mid_reset();
`ifdef MATCH_LOGGER_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
